// File: rtl/cpu_clk_enable.sv
// Fractional clock-enable generator: a phase accumulator on the 84 MHz clock issues
// rising/falling CPU strobes, sequences CPU reset and counts CPU cycles.
module cpu_clk_enable #(
  parameter int ACC_W      = 24,
  parameter int INC_SLOW   = 354334,
  parameter int INC_FAST   = 404954,
  parameter int INC_TURBO  = 1018640,
  parameter int RST_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  speed,
  input  logic        pause,
  output logic        cpu_ce,
  output logic        cpu_ce_fall,
  output logic        cpu_rst,
  output logic [1:0]  speed_cur,
  output logic [31:0] cycle_count
);

  localparam int RST_W = (RST_CYCLES < 1) ? 1 : $clog2(RST_CYCLES + 1);

  function automatic logic [ACC_W-1:0] inc_for(input logic [1:0] spd);
    logic [ACC_W-1:0] inc;
    case (spd)
      2'd0:    inc = ACC_W'(INC_SLOW);
      2'd1:    inc = ACC_W'(INC_FAST);
      default: inc = ACC_W'(INC_TURBO);
    endcase
    return inc;
  endfunction

  function automatic logic [RST_W-1:0] sat_inc(input logic [RST_W-1:0] cnt);
    return (cnt < RST_W'(RST_CYCLES)) ? cnt + RST_W'(1) : cnt;
  endfunction

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic [1:0]       speed_cur_q, speed_cur_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [31:0]      cycle_count_q, cycle_count_d;
  logic             cpu_ce_q, cpu_ce_d;
  logic             cpu_ce_fall_q, cpu_ce_fall_d;

  logic [ACC_W:0]   sum;
  logic             advance;
  logic             carry;
  logic             half;

  always_comb begin
    sum           = {1'b0, acc_q} + {1'b0, inc_q};
    advance       = ~pause;
    carry         = advance & sum[ACC_W];
    // Mid-period crossing of the MSB gives the falling-phase strobe; a wrap never does.
    half          = advance & ~acc_q[ACC_W-1] & sum[ACC_W-1] & ~sum[ACC_W];

    acc_d         = advance ? sum[ACC_W-1:0] : acc_q;
    speed_cur_d   = carry ? speed : speed_cur_q;
    // New rate only reaches the adder after the boundary, so acc keeps its phase.
    inc_d         = inc_for(speed_cur_d);
    rst_cnt_d     = carry ? sat_inc(rst_cnt_q) : rst_cnt_q;
    cycle_count_d = cycle_count_q + {31'd0, carry};
    cpu_ce_d      = carry;
    cpu_ce_fall_d = half;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q         <= '0;
      inc_q         <= inc_for(2'd0);
      speed_cur_q   <= 2'd0;
      rst_cnt_q     <= '0;
      cycle_count_q <= '0;
      cpu_ce_q      <= 1'b0;
      cpu_ce_fall_q <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      inc_q         <= inc_d;
      speed_cur_q   <= speed_cur_d;
      rst_cnt_q     <= rst_cnt_d;
      cycle_count_q <= cycle_count_d;
      cpu_ce_q      <= cpu_ce_d;
      cpu_ce_fall_q <= cpu_ce_fall_d;
    end
  end

  assign cpu_ce      = cpu_ce_q;
  assign cpu_ce_fall = cpu_ce_fall_q;
  assign cpu_rst     = (rst_cnt_q < RST_W'(RST_CYCLES));
  assign speed_cur   = speed_cur_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_clk_enable.sv
// Bench for cpu_clk_enable: a small-accumulator instance against a phase-arithmetic
// scoreboard, plus a default-parameter instance checked for rate and spacing.
module tb_cpu_clk_enable;

  localparam int AW  = 8;
  localparam int M   = 256;
  localparam int I_S = 64;
  localparam int I_F = 32;
  localparam int I_T = 100;
  localparam int RC  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        a_reset, a_pause, a_ce, a_fall, a_rst;
  logic [1:0]  a_speed, a_spd;
  logic [31:0] a_cnt;

  logic        b_reset, b_pause, b_ce, b_fall, b_rst;
  logic [1:0]  b_speed, b_spd;
  logic [31:0] b_cnt;

  cpu_clk_enable #(.ACC_W(AW), .INC_SLOW(I_S), .INC_FAST(I_F), .INC_TURBO(I_T),
                   .RST_CYCLES(RC)) dut_a (
    .clk(clk), .reset(a_reset), .speed(a_speed), .pause(a_pause),
    .cpu_ce(a_ce), .cpu_ce_fall(a_fall), .cpu_rst(a_rst),
    .speed_cur(a_spd), .cycle_count(a_cnt));

  cpu_clk_enable dut_b (
    .clk(clk), .reset(b_reset), .speed(b_speed), .pause(b_pause),
    .cpu_ce(b_ce), .cpu_ce_fall(b_fall), .cpu_rst(b_rst),
    .speed_cur(b_spd), .cycle_count(b_cnt));

  typedef struct {
    int          c;
    logic        ce;
    logic        fall;
    logic        rst;
    logic [1:0]  spd;
    logic [31:0] cnt;
  } exp_t;

  exp_t expq[$];

  // Reference: total phase since reset as an unbounded integer; a CPU period ends
  // whenever the phase crosses a multiple of M.
  longint      ph = 0;
  int          spd_m = 0;
  int          rcnt = 0;
  logic [31:0] cnt_m = '0;

  function automatic int inc_of(input int s);
    return (s == 0) ? I_S : ((s == 1) ? I_F : I_T);
  endfunction

  task automatic step(input logic r, input logic [1:0] s, input logic p, input logic do_force);
    exp_t   e;
    longint np;
    logic   ce, fall;
    @(negedge clk);
    if (do_force) begin
      force dut_a.cycle_count_q = 32'hFFFF_FFFF;
      #1;
      release dut_a.cycle_count_q;
      cnt_m = 32'hFFFF_FFFF;
    end
    a_reset = r;
    a_speed = s;
    a_pause = p;
    ce   = 1'b0;
    fall = 1'b0;
    if (r) begin
      ph = 0; spd_m = 0; rcnt = 0; cnt_m = '0;
    end else if (!p) begin
      np   = ph + longint'(inc_of(spd_m));
      ce   = (np / M) != (ph / M);
      fall = !ce && ((np % M) >= M / 2) && ((ph % M) < M / 2);
      ph   = np;
      if (ce) begin
        spd_m = int'(s);
        if (rcnt < RC) rcnt++;
        cnt_m = cnt_m + 32'd1;
      end
    end
    e.c    = cyc + 1;
    e.ce   = ce;
    e.fall = fall;
    e.rst  = (rcnt < RC);
    e.spd  = 2'(spd_m);
    e.cnt  = cnt_m;
    expq.push_back(e);
  endtask

  // Scoreboard monitor for instance A.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (expq.size() > 0 && expq[0].c < cyc) begin
        e = expq.pop_front();
        checks++; errors++;
        $display("FAIL a_stale: expectation for cycle %0d not compared (now %0d)", e.c, cyc);
      end
      if (expq.size() > 0 && expq[0].c == cyc) begin
        e = expq.pop_front();
        checks++;
        if ({a_ce, a_fall, a_rst, a_spd, a_cnt} !== {e.ce, e.fall, e.rst, e.spd, e.cnt}) begin
          errors++;
          $display("FAIL a_cycle %0d: got ce=%b fall=%b rst=%b spd=%0d cnt=%h, want ce=%b fall=%b rst=%b spd=%0d cnt=%h",
                   cyc, a_ce, a_fall, a_rst, a_spd, a_cnt, e.ce, e.fall, e.rst, e.spd, e.cnt);
        end
      end
    end
  end

  // Spacing monitor for the default-parameter instance.
  logic b_run = 1'b0;
  int   b_last = -1;
  int   b_last_spd = 0;
  initial begin
    int lo, sp;
    forever begin
      @(posedge clk);
      #1;
      if (!b_run) begin
        b_last = -1;
      end else begin
        if (b_ce && b_fall) begin
          checks++; errors++;
          $display("FAIL b_overlap: ce and ce_fall both high at cycle %0d", cyc);
        end
        if (b_ce) begin
          if (b_last >= 0) begin
            lo = 16777216 / (b_last_spd == 0 ? 354334 : (b_last_spd == 1 ? 404954 : 1018640));
            sp = cyc - b_last;
            checks++;
            if (sp != lo && sp != lo + 1) begin
              errors++;
              $display("FAIL b_spacing: got %0d cycles, want %0d or %0d", sp, lo, lo + 1);
            end
          end
          b_last     = cyc;
          b_last_spd = int'(b_spd);
        end
      end
    end
  end

  task automatic run_a();
    logic [1:0] s;
    int         pause_left;
    a_reset = 1'b1; a_speed = 2'd0; a_pause = 1'b0;
    repeat (3) step(1'b1, 2'd0, 1'b0, 1'b0);
    // Basic rate, falling strobe and reset release
    repeat (40) step(1'b0, 2'd0, 1'b0, 1'b0);
    // Mid-period speed change 0 -> 1 and back
    repeat (2) step(1'b0, 2'd0, 1'b0, 1'b0);
    repeat (40) step(1'b0, 2'd1, 1'b0, 1'b0);
    repeat (30) step(1'b0, 2'd0, 1'b0, 1'b0);
    // Pause between pulses
    step(1'b0, 2'd0, 1'b0, 1'b0);
    repeat (10) step(1'b0, 2'd0, 1'b1, 1'b0);
    repeat (20) step(1'b0, 2'd0, 1'b0, 1'b0);
    // Counter wrap
    step(1'b0, 2'd0, 1'b0, 1'b1);
    repeat (20) step(1'b0, 2'd0, 1'b0, 1'b0);
    // Reset mid-operation at cycle_count 500
    step(1'b1, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3000 && cnt_m < 32'd500; i++) step(1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b0, 1'b0);
    repeat (20) step(1'b0, 2'd2, 1'b0, 1'b0);
    // Randomized traffic
    s = 2'd0;
    pause_left = 0;
    repeat (5000) begin
      if ($urandom_range(0, 29) == 0) s = 2'($urandom_range(0, 3));
      if (pause_left == 0 && $urandom_range(0, 59) == 0) pause_left = $urandom_range(1, 12);
      step(($urandom_range(0, 799) == 0), s, (pause_left > 0), ($urandom_range(0, 1999) == 0));
      if (pause_left > 0) pause_left--;
    end
    repeat (3) step(1'b0, s, 1'b0, 1'b0);
  endtask

  task automatic run_b();
    real want, got;
    b_reset = 1'b1; b_speed = 2'd0; b_pause = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      b_reset = 1'b1;
      b_speed = 2'(s);
      @(negedge clk);
      b_reset = 1'b0;
      b_run   = 1'b1;
      repeat (20000) @(negedge clk);
      b_run = 1'b0;
      want = 20000.0 * real'(s == 0 ? 354334 : 404954) / 16777216.0;
      got  = real'(b_cnt);
      checks++;
      if (got > want + 1.0 || got < want - 1.0) begin
        errors++;
        $display("FAIL b_rate speed %0d: got %0d pulses, want %f +-1", s, b_cnt, want);
      end
      checks++;
      if (b_rst !== 1'b0) begin
        errors++;
        $display("FAIL b_cpu_rst: got %b after reset sequence, want 0", b_rst);
      end
    end
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    repeat (3) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL a_drain: got %0d pending expectations, want 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
